// File: rtl/urv_writeback.sv
// Writeback stage: commits ALU/divider results and sign/zero-extended load
// data to the register file, stalling upstream while a load is in flight.
module urv_writeback (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        x_rd_write_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        rf_rd_write_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        w_stall_req_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [2:0] FUN_LB  = 3'b000;
  localparam logic [2:0] FUN_LH  = 3'b001;
  localparam logic [2:0] FUN_LBU = 3'b100;
  localparam logic [2:0] FUN_LHU = 3'b101;

  state_t      state_q;
  logic        rf_we_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_val_q;
  logic [4:0]  ld_rd_q;
  logic        ld_we_q;
  logic [2:0]  ld_fun_q;
  logic [1:0]  ld_addr_q;

  logic        capture;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign capture = x_valid_i & ~x_stall_i & ~x_kill_i
                 & (state_q == IDLE);

  // Pick the addressed byte/halfword and extend per the latched load type
  always_comb begin
    ld_byte = dm_data_l_i[7:0];
    ld_half = ld_addr_q[1] ? dm_data_l_i[31:16]
                           : dm_data_l_i[15:0];
    ld_ext  = dm_data_l_i;
    unique case (ld_addr_q)
      2'd0: ld_byte = dm_data_l_i[7:0];
      2'd1: ld_byte = dm_data_l_i[15:8];
      2'd2: ld_byte = dm_data_l_i[23:16];
      2'd3: ld_byte = dm_data_l_i[31:24];
    endcase
    case (ld_fun_q)
      FUN_LB:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      FUN_LBU: ld_ext = {24'd0, ld_byte};
      FUN_LH:  ld_ext = {{16{ld_half[15]}}, ld_half};
      FUN_LHU: ld_ext = {16'd0, ld_half};
      default: ld_ext = dm_data_l_i;
    endcase
  end

  // FSM with registered register-file write port
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_val_q  <= 32'd0;
      ld_rd_q   <= 5'd0;
      ld_we_q   <= 1'b0;
      ld_fun_q  <= 3'd0;
      ld_addr_q <= 2'd0;
    end else begin
      rf_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            if (x_load_i) begin
              ld_rd_q   <= x_rd_i;
              ld_we_q   <= x_rd_write_i;
              ld_fun_q  <= x_fun_i;
              ld_addr_q <= x_dm_addr_i;
              state_q   <= WAIT_LOAD;
            end else begin
              rf_we_q  <= x_rd_write_i & (x_rd_i != 5'd0);
              rf_rd_q  <= x_rd_i;
              rf_val_q <= x_rd_value_i;
            end
          end
        end
        WAIT_LOAD: begin
          if (dm_load_done_i) begin
            rf_we_q  <= ld_we_q & (ld_rd_q != 5'd0);
            rf_rd_q  <= ld_rd_q;
            rf_val_q <= ld_ext;
            state_q  <= IDLE;
          end
        end
      endcase
    end
  end

  assign rf_rd_write_o = rf_we_q;
  assign rf_rd_o       = rf_rd_q;
  assign rf_rd_value_o = rf_val_q;
  assign w_stall_req_o = (state_q == WAIT_LOAD);

endmodule

// File: doc/urv_writeback.md
URV_WRITEBACK -- requirements
Module: urv_writeback

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports in this order: clk_i, then rst_n_i.
REQ-002 SHALL have port clk_i, input, width 1: rising-edge clock.
REQ-003 SHALL have port rst_n_i, input, width 1: asynchronous active-low reset.
REQ-004 SHALL have port x_valid_i, input, width 1: execute-stage instruction valid.
REQ-005 SHALL have port x_stall_i, input, width 1: execute stall, including the divider stall request.
REQ-006 SHALL have port x_kill_i, input, width 1: execute-stage instruction killed.
REQ-007 SHALL have port x_rd_write_i, input, width 1: instruction writes rd.
REQ-008 SHALL have port x_rd_i, input, width 5: destination register index.
REQ-009 SHALL have port x_rd_value_i, input, width 32: ALU or divider result (divider x_rd_o).
REQ-010 SHALL have port x_load_i, input, width 1: instruction is a load.
REQ-011 SHALL have port x_fun_i, input, width 3: load function, encoded LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-012 SHALL have port x_dm_addr_i, input, width 2: low address bits of the load.
REQ-013 SHALL have port dm_data_l_i, input, width 32: raw load word from the data bus.
REQ-014 SHALL have port dm_load_done_i, input, width 1: load data valid this cycle.
REQ-015 SHALL have port rf_rd_write_o, output, width 1: register-file write enable.
REQ-016 SHALL have port rf_rd_o, output, width 5: register-file write index.
REQ-017 SHALL have port rf_rd_value_o, output, width 32: register-file write data.
REQ-018 SHALL have port w_stall_req_o, output, width 1: request to stall upstream stages.

Function
REQ-019 SHALL define capture as the condition x_valid_i & !x_stall_i & !x_kill_i & (state==IDLE).
REQ-020 SHALL implement a two-state FSM, IDLE and WAIT_LOAD, with all outputs driven from registers except w_stall_req_o.
REQ-021 SHALL, on a non-load capture, set at the next edge rf_rd_write_o to x_rd_write_i & (x_rd_i!=0), rf_rd_o to x_rd_i, and rf_rd_value_o to x_rd_value_i, with state remaining IDLE.
REQ-022 SHALL hold rf_rd_write_o high for exactly one cycle per write and clear it at the next edge unless a new write occurs.
REQ-023 SHALL, on a load capture, at the next edge latch rd, the rd-write qualifier, x_fun_i and x_dm_addr_i, force rf_rd_write_o to 0, and move to WAIT_LOAD.
REQ-024 SHALL drive w_stall_req_o = (state==WAIT_LOAD) combinationally, including the cycle in which dm_load_done_i is high.
REQ-025 SHALL, in WAIT_LOAD with dm_load_done_i=1, at the next edge write the extended load data (rf_rd_write_o = qualifier & rd!=0) and return to IDLE.
REQ-026 SHALL extend LB/LBU by selecting byte addr[1:0] (byte 0 = bits 7:0) and sign- or zero-extending it to 32 bits.
REQ-027 SHALL extend LH/LHU by selecting the upper halfword when addr[1]=1 and the lower otherwise, ignoring addr[0], then sign- or zero-extending.
REQ-028 SHALL treat LW and all unlisted x_fun_i codes as passing the full word unchanged.
REQ-029 SHALL ignore dm_load_done_i while in IDLE.
REQ-030 SHALL ignore x_kill_i, x_valid_i and x_stall_i while in WAIT_LOAD, because an issued load is committed.
REQ-031 SHALL wait in WAIT_LOAD indefinitely, with no timeout, until dm_load_done_i is asserted.
REQ-032 SHALL never perform a capture and a load write-back at the same edge; this is guaranteed by REQ-019.

Reset
REQ-033 SHALL, while rst_n_i=0, immediately force state=IDLE, rf_rd_write_o=0, rf_rd_o=0 and rf_rd_value_o=0, giving w_stall_req_o=0.
REQ-034 SHALL, when reset is asserted during WAIT_LOAD, discard the pending load so that a later dm_load_done_i causes no write.
REQ-035 SHALL perform its first capture no earlier than the first clock edge after rst_n_i deasserts.

Verification
REQ-036 SHALL cover non-load write: capture with rd=5, value 0x12345678, rd_write=1 -> next cycle rf_rd_write_o=1, rf_rd_o=5, rf_rd_value_o=0x12345678; the following cycle rf_rd_write_o=0.
REQ-037 SHALL cover write to x0: capture with rd=0, rd_write=1, value 0xDEADBEEF -> rf_rd_write_o stays 0.
REQ-038 SHALL cover LB: LB addr=3 with dm_data_l_i=0x80FF1122 and done 3 cycles after capture -> w_stall_req_o high 4 cycles, then a one-cycle write with value 0xFFFFFF80.
REQ-039 SHALL cover LHU: LHU addr=2 with data 0x80010000 and done next cycle -> write 0x00008001; LH at the same address -> write 0xFFFF8001.
REQ-040 SHALL cover divider stall: x_valid_i=1 with x_stall_i=1 for 36 cycles -> no write; x_stall_i drops with value 0x00000007 -> one write of 0x00000007.
REQ-041 SHALL cover reset mid-load: rst_n_i pulsed low in WAIT_LOAD, then dm_load_done_i=1 -> all outputs 0 and no write.
